jtframe_dwnld_router: RTL and testbench

//  Routes the ioctl byte stream from the frame's ROM downloader into SDRAM write

---
 rtl/jtframe_dwnld_router.sv | 120 ++++++++++++
 tb/tb_jtframe_dwnld_router.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_dwnld_router.sv
// jtframe_dwnld_router: routes ioctl download bytes into SDRAM write requests or
// one-hot PROM strobes through a 4-entry FIFO, with overflow flag and done pulse.
module jtframe_dwnld_router #(
    parameter int                      AW       = 22,
    parameter int                      REGIONS  = 4,
    parameter logic [REGIONS*AW-1:0]   BOUNDS   = '0,
    parameter logic [REGIONS*AW-1:0]   OFFSETS  = '0,
    parameter logic [REGIONS-1:0]      PROM_SEL = '0,
    parameter bit                      SWAB     = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               downloading,
    input  logic [AW-1:0]      ioctl_addr,
    input  logic [7:0]         ioctl_data,
    input  logic               ioctl_wr,
    output logic [AW-1:0]      prog_addr,
    output logic [15:0]        prog_data,
    output logic [1:0]         prog_mask,
    output logic               prog_we,
    input  logic               prog_ack,
    output logic [AW-1:0]      prom_addr,
    output logic [7:0]         prom_data,
    output logic [REGIONS-1:0] prom_we,
    output logic               overflow,
    output logic               dwnld_done
);
    localparam int RW = REGIONS > 1 ? $clog2(REGIONS) : 1;
    localparam int EW = 2 + RW + AW + 8;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, GAP} state_t;
    state_t state, state_nxt;

    logic [EW-1:0] mem [4];
    logic [1:0]    wp, rp;
    logic [2:0]    cnt;
    logic          dl_q, done_pend, done_now;
    logic          rise, fall, pop, push, lost;
    logic [RW-1:0] reg_sel;
    logic [AW-1:0] base, ofs, rel, word;
    logic [EW-1:0] entry;
    logic          h_prom, h_lane;
    logic [RW-1:0] h_reg;
    logic [AW-1:0] h_val;
    logic [7:0]    h_byte;

    // Bounds are ascending, so the last region whose start is not above the address wins
    always_comb begin
        reg_sel = '0;
        base    = BOUNDS[AW-1:0];
        ofs     = OFFSETS[AW-1:0];
        for (int r = 1; r < REGIONS; r++)
            if (ioctl_addr >= BOUNDS[r*AW +: AW]) begin
                reg_sel = RW'(r);
                base    = BOUNDS[r*AW +: AW];
                ofs     = OFFSETS[r*AW +: AW];
            end
        rel   = ioctl_addr - base;
        word  = (rel >> 1) + ofs;
        entry = {PROM_SEL[reg_sel], rel[0] ^ SWAB, reg_sel, PROM_SEL[reg_sel] ? rel : word, ioctl_data};
    end

    assign {h_prom, h_lane, h_reg, h_val, h_byte} = mem[rp];

    assign rise     = downloading & ~dl_q;
    assign fall     = ~downloading & dl_q;
    assign pop      = state == IDLE && cnt != 3'd0 && !rise;
    // A restart flushes the FIFO, so a byte arriving on that cycle always fits
    assign push     = downloading && ioctl_wr && (rise || cnt != 3'd4 || pop);
    assign lost     = downloading && ioctl_wr && !push;
    assign done_now = (done_pend || fall) && !rise && cnt == 3'd0 && state == IDLE;
    assign prog_we  = state == WAIT_ACK;

    always_comb begin
        state_nxt = rise              ? IDLE :
                    state == IDLE     ? ((pop && !h_prom) ? WAIT_ACK : IDLE) :
                    state == WAIT_ACK ? (prog_ack ? GAP : WAIT_ACK) : IDLE;
    end

    always_ff @(posedge clk)
        if (push) mem[rise ? 2'd0 : wp] <= entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            wp         <= '0;
            rp         <= '0;
            cnt        <= '0;
            dl_q       <= 1'b0;
            done_pend  <= 1'b0;
            overflow   <= 1'b0;
            dwnld_done <= 1'b0;
            prog_addr  <= '0;
            prog_data  <= '0;
            prog_mask  <= '0;
            prom_addr  <= '0;
            prom_data  <= '0;
            prom_we    <= '0;
        end else begin
            state      <= state_nxt;
            dl_q       <= downloading;
            wp         <= (rise ? 2'd0 : wp) + 2'(push);
            rp         <= rise ? 2'd0 : rp + 2'(pop);
            cnt        <= (rise ? 3'd0 : cnt - 3'(pop)) + 3'(push);
            overflow   <= !rise && (overflow || lost);
            done_pend  <= (done_pend || fall) && !rise && !done_now;
            dwnld_done <= done_now;
            prom_we    <= (pop && h_prom) ? REGIONS'(1) << h_reg : '0;
            if (pop && !h_prom) begin
                prog_addr <= h_val;
                prog_data <= {h_byte, h_byte};
                prog_mask <= h_lane ? 2'b01 : 2'b10;
            end
            if (pop && h_prom) begin
                prom_addr <= h_val;
                prom_data <= h_byte;
            end
        end
    end
endmodule

// File: tb/tb_jtframe_dwnld_router.sv
// tb_jtframe_dwnld_router: random and directed download streams checked against
// an ordered queue of expected writes computed from the region map.
module tb_jtframe_dwnld_router;
    localparam int AW = 22;
    localparam int R  = 3;

    logic          clk = 1'b0;
    logic          rst_n, downloading, ioctl_wr, prog_ack, prog_we, overflow, dwnld_done;
    logic [AW-1:0] ioctl_addr, prog_addr, prom_addr;
    logic [7:0]    ioctl_data, prom_data;
    logic [15:0]   prog_data;
    logic [1:0]    prog_mask;
    logic [R-1:0]  prom_we;

    jtframe_dwnld_router #(
        .AW(AW), .REGIONS(R),
        .BOUNDS({22'h10000, 22'h08000, 22'h0}),
        .OFFSETS({22'h0, 22'h100000, 22'h0}),
        .PROM_SEL(3'b100), .SWAB(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask),
        .prog_we(prog_we), .prog_ack(prog_ack),
        .prom_addr(prom_addr), .prom_data(prom_data), .prom_we(prom_we),
        .overflow(overflow), .dwnld_done(dwnld_done)
    );

    always #5 clk = ~clk;

    typedef struct {bit prom; int addr; int data; int mask; int we;} wr_t;
    wr_t exp_q[$];
    int  checks = 0, errors = 0, done_cnt = 0, prog_seen = 0;
    bit  mon_en = 0, ack_auto = 0, we_q = 0;
    int  ack_dly = 3;
    logic [AW+17:0] held;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Region map restated as plain integers: starts 0/0x8000/0x10000, region 2 is PROM
    function automatic wr_t ref_wr(input int a, input int d);
        int b[3];
        int o[3];
        int r, rel;
        wr_t w;
        b = '{0, 'h8000, 'h10000};
        o = '{0, 'h100000, 0};
        r = a >= b[2] ? 2 : a >= b[1] ? 1 : 0;
        rel = a - b[r];
        w.prom = (r == 2);
        w.addr = w.prom ? rel : (rel / 2 + o[r]) % (1 << AW);
        w.data = w.prom ? d : d * 257;
        w.mask = (rel % 2) ? 1 : 2;
        w.we   = 1 << r;
        return w;
    endfunction

    task automatic send(input int a, input int d, input bit expect_it);
        @(negedge clk);
        ioctl_addr = AW'(a);
        ioctl_data = 8'(d);
        ioctl_wr   = 1'b1;
        if (expect_it) exp_q.push_back(ref_wr(a, d));
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || prog_we) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", n < 500, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_we();
        int n = 0;
        while (!prog_we && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("wait_prog_we", prog_we, 1);
    endtask

    // Output monitor: every new write must match the head of the expected queue
    initial begin
        wr_t w;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (dwnld_done) begin
                    done_cnt++;
                    check("done_drained", exp_q.size() == 0 && !prog_we, 1);
                end
                if (prog_we && !we_q) begin
                    prog_seen++;
                    check("prog_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        check("prog_kind", w.prom, 0);
                        check("prog_addr", prog_addr, w.addr);
                        check("prog_data", prog_data, w.data);
                        check("prog_mask", prog_mask, w.mask);
                    end
                    held = {prog_addr, prog_data, prog_mask};
                end else if (prog_we) begin
                    check("prog_hold", {prog_addr, prog_data, prog_mask}, held);
                end
                if (prom_we != '0) begin
                    check("prom_expected", exp_q.size() != 0, 1);
                    check("prom_no_prog", prog_we, 0);
                    if (exp_q.size() != 0) begin
                        w = exp_q.pop_front();
                        check("prom_kind", w.prom, 1);
                        check("prom_we", prom_we, w.we);
                        check("prom_addr", prom_addr, w.addr);
                        check("prom_data", prom_data, w.data);
                    end
                end
                we_q = prog_we;
            end
        end
    end

    initial begin
        prog_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (prog_we && ack_auto) begin
                repeat (ack_dly < 0 ? int'($urandom_range(0, 3)) : ack_dly) @(negedge clk);
                prog_ack = 1'b1;
                @(negedge clk);
                prog_ack = 1'b0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bnd[6];
        int a, d0;
        bnd = '{'h7fff, 'h8000, 'h8001, 'hffff, 'h10000, 'h10001};
        rst_n = 1'b1; downloading = 1'b0; ioctl_wr = 1'b0; ioctl_addr = '0; ioctl_data = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_prog_we", prog_we, 0);
        check("rst_prom_we", prom_we, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", dwnld_done, 0);
        check("rst_prog_addr", prog_addr, 0);
        check("rst_prog_mask", prog_mask, 0);
        rst_n = 1'b1;
        mon_en = 1;
        @(negedge clk);
        downloading = 1'b1;
        ack_auto = 1; ack_dly = 3;
        repeat (2) @(negedge clk);
        // First-byte latency: pushed on the next edge, issued on the one after
        ioctl_addr = '0; ioctl_data = 8'h12; ioctl_wr = 1'b1;
        exp_q.push_back(ref_wr(0, 'h12));
        @(negedge clk);
        ioctl_wr = 1'b0;
        check("lat_edge1", prog_we, 0);
        @(negedge clk);
        check("lat_edge2", prog_we, 1);
        send(1, 'h34, 1);
        send('h8003, 'hab, 1);
        send('h10010, 'h5c, 1);
        drain();
        ack_dly = -1;
        for (int i = 0; i < 30; i++) begin
            a = ($urandom_range(0, 3) == 0) ? bnd[$urandom_range(0, 5)] : int'($urandom_range(0, 'h17fff));
            send(a, int'($urandom_range(0, 255)), 1);
            repeat ($urandom_range(6, 9)) @(negedge clk);
        end
        drain();
        check("no_overflow", overflow, 0);
        check("no_done_yet", done_cnt, 0);
        downloading = 1'b0;
        repeat (5) @(negedge clk);
        check("done_idle", done_cnt, 1);
        // Overflow: no acks, six strobes on consecutive cycles
        downloading = 1'b1;
        ack_auto = 0;
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            ioctl_addr = AW'('h200 + i); ioctl_data = 8'(i + 1); ioctl_wr = 1'b1;
            if (i < 5) exp_q.push_back(ref_wr('h200 + i, i + 1));
            @(negedge clk);
        end
        ioctl_wr = 1'b0;
        repeat (3) @(negedge clk);
        check("ovf_set", overflow, 1);
        check("ovf_in_flight", prog_we, 1);
        check("ovf_queued", exp_q.size(), 4);
        ack_auto = 1; ack_dly = 0;
        drain();
        check("ovf_sticky", overflow, 1);
        // Eight bytes, download ends while some are still queued
        ack_dly = 1;
        for (int i = 0; i < 8; i++) begin
            send('h8100 + 2 * i + (i % 2), 'h40 + i, 1);
            @(negedge clk);
        end
        downloading = 1'b0;
        @(negedge clk);
        check("done_not_early", done_cnt, 1);
        check("queued_at_end", exp_q.size() != 0, 1);
        drain();
        check("done_after_drain", done_cnt, 2);
        check("ovf_still_set", overflow, 1);
        // Writes while not downloading must vanish
        d0 = prog_seen;
        send(4, 'h77, 0);
        send('h10004, 'h66, 0);
        repeat (10) @(negedge clk);
        check("ignored_writes", prog_seen, d0);
        check("ignored_done", done_cnt, 2);
        downloading = 1'b1;
        repeat (2) @(negedge clk);
        check("ovf_cleared", overflow, 0);
        // Restart during WAIT_ACK drops the pending write and the queued byte
        ack_auto = 0;
        send(6, 'h11, 1);
        wait_we();
        send(8, 'h22, 0);
        downloading = 1'b0;
        @(negedge clk);
        downloading = 1'b1;
        @(negedge clk);
        check("restart_drop", prog_we, 0);
        d0 = prog_seen;
        repeat (10) @(negedge clk);
        check("restart_flush", prog_seen, d0);
        check("restart_no_done", done_cnt, 2);
        // Asynchronous reset in the middle of WAIT_ACK
        send(10, 'h33, 1);
        wait_we();
        send(12, 'h44, 0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_prog_we", prog_we, 0);
        check("arst_overflow", overflow, 0);
        downloading = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        d0 = prog_seen;
        repeat (15) @(negedge clk);
        check("arst_fifo_empty", prog_seen, d0);
        check("arst_no_done", done_cnt, 2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
